// File: rtl/seq_det_pkg.sv
// ---------------------------------------------------------------------------
// seq_det_pkg
// Shared definitions for the parametrised serial pattern detector.
//   SEQ_LEN_MAX : largest supported pattern length.
//   mode_e      : match mode encoding (non-overlapping / overlapping).
// ---------------------------------------------------------------------------
package seq_det_pkg;

    localparam int SEQ_LEN_MAX = 32;

    typedef enum logic {
        MODE_NONOVL = 1'b0,
        MODE_OVL    = 1'b1
    } mode_e;

endpackage : seq_det_pkg

// File: rtl/sat_counter.sv
// ---------------------------------------------------------------------------
// sat_counter
// Generic up-counter that saturates at all-ones.
//   clk : clock, rising edge
//   rst : synchronous active-high reset, clears q
//   clr : clear q; if inc is also high the result is 1 (both honoured)
//   inc : count one event
//   q   : current count, W bits
// ---------------------------------------------------------------------------
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);

    localparam logic [W-1:0] Q_MAX = '1;

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (clr) begin
            // A clear coinciding with an event keeps that event.
            q <= inc ? W'(1) : '0;
        end else if (inc && (q != Q_MAX)) begin
            q <= q + W'(1);
        end
    end

endmodule : sat_counter

// File: rtl/seq_detector_param.sv
// ---------------------------------------------------------------------------
// seq_detector_param
// Bit-serial pattern detector with a runtime-programmable SEQ_LEN-bit pattern
// (legal SEQ_LEN 2..SEQ_LEN_MAX), overlapping or non-overlapping matching,
// input qualification and a saturating match counter.
//   clk         : clock, rising edge
//   rst         : synchronous active-high reset (highest priority)
//   in          : serial data bit
//   in_valid    : in is accepted only when high
//   cfg_load    : latch cfg_pattern/cfg_overlap and restart detection
//   cfg_pattern : new pattern; MSB is compared with the first-received bit
//   cfg_overlap : 1 = overlapping matches, 0 = non-overlapping
//   cnt_clr     : clear match_count
//   match       : registered one-cycle pulse per detected occurrence
//   match_count : saturating count of matches
//   armed       : registered, high while the window holds SEQ_LEN bits
// ---------------------------------------------------------------------------
module seq_detector_param
    import seq_det_pkg::*;
#(
    parameter int                 SEQ_LEN     = 4,
    parameter int                 CNT_W       = 8,
    parameter logic [SEQ_LEN-1:0] RST_PATTERN = SEQ_LEN'(4'b1001)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in,
    input  logic               in_valid,
    input  logic               cfg_load,
    input  logic [SEQ_LEN-1:0] cfg_pattern,
    input  logic               cfg_overlap,
    input  logic               cnt_clr,
    output logic               match,
    output logic [CNT_W-1:0]   match_count,
    output logic               armed
);

    localparam int                FILL_W    = $clog2(SEQ_LEN + 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(SEQ_LEN);
    localparam logic [FILL_W-1:0] FILL_HIT  = FILL_W'(SEQ_LEN - 1);

    logic [SEQ_LEN-1:0] pat_q;
    mode_e              ovl_q;
    logic [SEQ_LEN-1:0] hist;
    logic [FILL_W-1:0]  fill;

    logic [SEQ_LEN-1:0] window;
    logic [SEQ_LEN-1:0] hist_n;
    logic [FILL_W-1:0]  fill_n;
    logic               accept;
    logic               hit;

    // Hit detection and next window/fill state.
    // NOTE: every always_comb output gets a default first, so no path
    // through the block can leave a value unassigned and infer a latch.
    always_comb begin
        window = {hist[SEQ_LEN-2:0], in};
        accept = in_valid && !cfg_load;
        // SEQ_LEN-1 earlier bits plus the incoming one form a full window.
        hit    = accept && (fill >= FILL_HIT) && (window == pat_q);
        hist_n = hist;
        fill_n = fill;

        if (cfg_load) begin
            hist_n = '0;
            fill_n = '0;
        end else if (accept) begin
            hist_n = window;
            if (hit && (ovl_q == MODE_NONOVL)) begin
                // Bits consumed by this hit may not start the next one.
                fill_n = '0;
            end else if (fill != FILL_FULL) begin
                fill_n = fill + FILL_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pat_q <= RST_PATTERN;
            ovl_q <= MODE_NONOVL;
            hist  <= '0;
            fill  <= '0;
            match <= 1'b0;
            armed <= 1'b0;
        end else begin
            if (cfg_load) begin
                pat_q <= cfg_pattern;
                ovl_q <= mode_e'(cfg_overlap);
            end
            hist  <= hist_n;
            fill  <= fill_n;
            match <= hit;
            armed <= (fill_n == FILL_FULL);
        end
    end

    sat_counter #(
        .W (CNT_W)
    ) u_cnt (
        .clk (clk),
        .rst (rst),
        .clr (cnt_clr),
        .inc (hit),
        .q   (match_count)
    );

endmodule : seq_detector_param

// File: tb/tb_seq_detector_param.sv
// ---------------------------------------------------------------------------
// tb_seq_detector_param
// Directed bench for seq_detector_param. Two instances share stimulus:
//   u_dut4 : SEQ_LEN=4, CNT_W=8 (default pattern 1001)
//   u_dut8 : SEQ_LEN=8, CNT_W=2 (generic width and counter saturation)
// Inputs are driven 1 ns after the rising edge and outputs are sampled there.
// ---------------------------------------------------------------------------
module tb_seq_detector_param;

    logic       clk = 1'b0;
    logic       rst;
    logic       in;
    logic       in_valid;
    logic       cfg_load;
    logic       cfg_overlap;
    logic       cnt_clr;
    logic [3:0] pat4;
    logic [7:0] pat8;

    logic       match4, armed4;
    logic [7:0] count4;
    logic       match8, armed8;
    logic [1:0] count8;

    int n_checks = 0;
    int n_fail   = 0;
    int hits4    = 0;
    int hits8    = 0;

    always #5 clk = ~clk;

    seq_detector_param #(
        .SEQ_LEN (4),
        .CNT_W   (8)
    ) u_dut4 (
        .clk         (clk),
        .rst         (rst),
        .in          (in),
        .in_valid    (in_valid),
        .cfg_load    (cfg_load),
        .cfg_pattern (pat4),
        .cfg_overlap (cfg_overlap),
        .cnt_clr     (cnt_clr),
        .match       (match4),
        .match_count (count4),
        .armed       (armed4)
    );

    seq_detector_param #(
        .SEQ_LEN     (8),
        .CNT_W       (2),
        .RST_PATTERN (8'hA5)
    ) u_dut8 (
        .clk         (clk),
        .rst         (rst),
        .in          (in),
        .in_valid    (in_valid),
        .cfg_load    (cfg_load),
        .cfg_pattern (pat8),
        .cfg_overlap (cfg_overlap),
        .cnt_clr     (cnt_clr),
        .match       (match8),
        .match_count (count8),
        .armed       (armed8)
    );

    task automatic check(input string tag, input logic [31:0] actual,
                         input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    // One clock; tallies match pulses seen on each instance.
    task automatic tick();
        @(posedge clk);
        #1;
        if (match4 === 1'b1) hits4++;
        if (match8 === 1'b1) hits8++;
    endtask

    task automatic step(input logic valid, input logic bit_in);
        in_valid = valid;
        in       = bit_in;
        tick();
        in_valid = 1'b0;
    endtask

    // Sends the low n bits of 'bits', most significant first.
    task automatic send_bits(input logic [31:0] bits, input int n);
        for (int i = n - 1; i >= 0; i--) step(1'b1, bits[i]);
    endtask

    task automatic load(input logic [3:0] p4, input logic [7:0] p8,
                        input logic ovl, input logic clr);
        pat4        = p4;
        pat8        = p8;
        cfg_overlap = ovl;
        cnt_clr     = clr;
        cfg_load    = 1'b1;
        tick();
        cfg_load    = 1'b0;
        cnt_clr     = 1'b0;
        hits4       = 0;
        hits8       = 0;
    endtask

    initial begin
        rst = 1'b1; in = 1'b0; in_valid = 1'b0; cfg_load = 1'b0;
        cfg_overlap = 1'b0; cnt_clr = 1'b0; pat4 = '0; pat8 = '0;
        tick();
        tick();
        check("rst_match",  match4, 0);
        check("rst_count",  count4, 0);
        check("rst_armed",  armed4, 0);
        check("rst_count8", count8, 0);
        rst = 1'b0;

        // Reset to first match with the default pattern 1001.
        hits4 = 0;
        send_bits(32'b100, 3);
        check("first_no_early", hits4, 0);
        step(1'b1, 1'b1);
        check("first_match", match4, 1);
        check("first_count", count4, 1);
        check("first_armed_after_nonovl_hit", armed4, 0);
        step(1'b0, 1'b0);
        check("first_pulse_width", match4, 0);

        // Overlapping vs non-overlapping on 1001001.
        load(4'b1001, 8'h00, 1'b1, 1'b1);
        check("load_clr_count", count4, 0);
        send_bits(32'b1001001, 7);
        check("ovl_hits",  hits4, 2);
        check("ovl_count", count4, 2);
        load(4'b1001, 8'h00, 1'b0, 1'b1);
        send_bits(32'b1001001, 7);
        check("nonovl_hits",  hits4, 1);
        check("nonovl_count", count4, 1);

        // armed rises exactly when the 4th bit is accepted without a hit.
        load(4'b1001, 8'h00, 1'b0, 1'b1);
        send_bits(32'b000, 3);
        check("armed_3_bits", armed4, 0);
        step(1'b1, 1'b0);
        check("armed_4_bits", armed4, 1);

        // Bubbles: 1,0,0,1 with gaps still matches once.
        load(4'b1001, 8'h00, 1'b0, 1'b1);
        step(1'b1, 1'b1); step(1'b0, 1'b0); step(1'b1, 1'b0); step(1'b0, 1'b1);
        step(1'b0, 1'b1); step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b1, 1'b1);
        check("bubble_match", match4, 1);
        check("bubble_hits",  hits4, 1);
        // A bubble carrying in=0 must not count as a 0 bit.
        load(4'b1001, 8'h00, 1'b0, 1'b1);
        step(1'b1, 1'b1); step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b1, 1'b1);
        check("bubble_not_a_bit", hits4, 0);

        // cfg_load after 1,0,0: the bit in the load cycle is discarded.
        load(4'b1001, 8'h00, 1'b0, 1'b1);
        send_bits(32'b100, 3);
        in = 1'b1;
        in_valid = 1'b1;
        load(4'b1001, 8'h00, 1'b0, 1'b0);
        in_valid = 1'b0;
        check("cfgload_cycle_no_match", match4, 0);
        step(1'b1, 1'b1);
        check("cfgload_next_1_no_match", match4, 0);
        send_bits(32'b001, 3);
        check("cfgload_full_new_match", match4, 1);
        check("cfgload_hits", hits4, 1);

        // rst after 1,0,0 behaves the same and clears the count.
        send_bits(32'b100, 3);
        rst = 1'b1; in = 1'b1; in_valid = 1'b1;
        tick();
        rst = 1'b0; in_valid = 1'b0;
        hits4 = 0;
        check("rst_mid_count", count4, 0);
        check("rst_mid_match", match4, 0);
        step(1'b1, 1'b1);
        check("rst_next_1_no_match", match4, 0);
        send_bits(32'b001, 3);
        check("rst_full_new_match", match4, 1);
        check("rst_new_count", count4, 1);

        // Generic width: SEQ_LEN=8, pattern A5, overlap, stream A5A5.
        load(4'b0000, 8'hA5, 1'b1, 1'b1);
        send_bits(32'b1010010, 7);
        check("w8_armed_7_bits", armed8, 0);
        step(1'b1, 1'b1);
        check("w8_armed_8_bits", armed8, 1);
        check("w8_first_match",  match8, 1);
        send_bits(32'hA5, 8);
        check("w8_hits",  hits8, 2);
        check("w8_count", count8, 2);

        // Saturation with CNT_W=2: twelve 1s against FF give five hits.
        load(4'b0000, 8'hFF, 1'b1, 1'b1);
        send_bits(32'hFFF, 12);
        check("sat_hits",  hits8, 5);
        check("sat_count", count8, 3);
        // Clear coinciding with a hit leaves a count of one.
        cnt_clr = 1'b1;
        step(1'b1, 1'b1);
        cnt_clr = 1'b0;
        check("clr_hit_match", match8, 1);
        check("clr_hit_count", count8, 1);
        step(1'b1, 1'b1);
        check("after_clr_count", count8, 2);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule : tb_seq_detector_param
